// File: rtl/dcm_ctrl_pkg.sv
// Shared definitions for the multi-DCM programming controller:
// serialiser state encoding, command constants and small helpers.
package dcm_ctrl_pkg;

  // Serialiser FSM: SHIFT walks frame states 0..25, WAIT_DONE is state 26.
  typedef enum logic [1:0] {
    SER_IDLE      = 2'd0,
    SER_SHIFT     = 2'd1,
    SER_WAIT_DONE = 2'd2
  } ser_state_e;

  // Broadcast command id: writes every channel's target.
  localparam logic [7:0]  CMD_ID_BCAST   = 8'hFF;
  // Marker in data2[63:32] that turns a work word into a command.
  localparam logic [31:0] CMD_TRIGGER    = 32'hFFFF_FFFF;
  // Channel index width (up to 8 DCMs).
  localparam int          CH_W           = 3;
  // Last shifted frame state before WAIT_DONE.
  localparam logic [4:0]  FRAME_LAST_IDX = 5'd25;

  // Saturate a requested multiplier into [lo, hi].
  function automatic logic [7:0] clamp_mult(input logic [7:0] v,
                                            input logic [7:0] lo,
                                            input logic [7:0] hi);
    logic [7:0] r;
    if (v > hi) begin
      r = hi;
    end else if (v < lo) begin
      r = lo;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // {en,data} driven during frame state idx; dm1 = D-1, mm1 = M-1, both LSB-first.
  function automatic logic [1:0] frame_bits(input logic [4:0] idx,
                                            input logic [7:0] dm1,
                                            input logic [7:0] mm1);
    logic [1:0] fb;
    if (idx == 5'd0) begin
      fb = 2'b11;
    end else if (idx == 5'd1) begin
      fb = 2'b10;
    end else if (idx <= 5'd9) begin
      fb = {1'b1, dm1[3'(idx - 5'd2)]};
    end else if (idx <= 5'd12) begin
      fb = 2'b00;
    end else if (idx <= 5'd14) begin
      fb = 2'b11;
    end else if (idx <= 5'd22) begin
      fb = {1'b1, mm1[3'(idx - 5'd15)]};
    end else if (idx == 5'd25) begin
      fb = 2'b10;
    end else begin
      fb = 2'b00;
    end
    return fb;
  endfunction

endpackage

// File: rtl/multi_dcm_controller_if.sv
// Per-channel serial programming bus between the controller and its DCMs.
interface multi_dcm_controller_if #(
  parameter int NUM_DCM = 2
);
  logic [NUM_DCM-1:0] dcm_prog_en;
  logic [NUM_DCM-1:0] dcm_prog_data;
  logic [NUM_DCM-1:0] dcm_prog_done;

  modport master (
    output dcm_prog_en,
    output dcm_prog_data,
    input  dcm_prog_done
  );

  modport slave (
    input  dcm_prog_en,
    input  dcm_prog_data,
    output dcm_prog_done
  );
endinterface

// File: rtl/dcm_prog_serializer.sv
// Shifts one DCM programming frame (states 0..26) onto the selected
// channel and waits for that channel's done, with a bounded timeout.
module dcm_prog_serializer
  import dcm_ctrl_pkg::*;
#(
  parameter int NUM_DCM      = 2,
  parameter int DIVIDER      = 8,
  parameter int DONE_TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [CH_W-1:0]    go_ch,
  input  logic [7:0]         go_mult,
  input  logic [NUM_DCM-1:0] prog_done,
  output logic [NUM_DCM-1:0] prog_en,
  output logic [NUM_DCM-1:0] prog_data,
  output logic               busy,
  output logic [CH_W-1:0]    frame_ch,
  output logic [7:0]         frame_mult,
  output logic               finish_ok,
  output logic               finish_timeout
);

  localparam logic [7:0] DIV_M1 = 8'(DIVIDER - 1);
  // Counter only has to reach DONE_TIMEOUT-1.
  localparam int TO_W = (DONE_TIMEOUT < 2) ? 1 : $clog2(DONE_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DONE_TIMEOUT - 1);

  ser_state_e      state_r;
  logic [4:0]      idx_r;
  logic [TO_W-1:0] to_cnt_r;

  logic            done_sel_s;
  logic            load_s;
  logic            shift_s;
  logic [4:0]      nxt_idx_s;
  logic [CH_W-1:0] nxt_ch_s;
  logic [7:0]      nxt_mult_s;
  logic [1:0]      nxt_bits_s;

  // Pick the done line of the channel owning the current frame.
  always_comb begin
    done_sel_s = 1'b0;
    for (int i = 0; i < NUM_DCM; i++) begin
      if (frame_ch == CH_W'(i)) begin
        done_sel_s = prog_done[i];
      end else begin
        done_sel_s = done_sel_s;
      end
    end
  end

  // Next frame bit to register and the completion strobes seen by the scheduler.
  always_comb begin
    load_s  = (state_r == SER_IDLE) && go;
    shift_s = (state_r == SER_SHIFT) && (idx_r != FRAME_LAST_IDX);
    if (load_s) begin
      nxt_idx_s  = 5'd0;
      nxt_ch_s   = go_ch;
      nxt_mult_s = go_mult;
    end else begin
      nxt_idx_s  = idx_r + 5'd1;
      nxt_ch_s   = frame_ch;
      nxt_mult_s = frame_mult;
    end
    nxt_bits_s     = frame_bits(nxt_idx_s, DIV_M1, nxt_mult_s - 8'd1);
    finish_ok      = (state_r == SER_WAIT_DONE) && done_sel_s;
    finish_timeout = (state_r == SER_WAIT_DONE) && !done_sel_s && (to_cnt_r == TO_LAST);
  end

  // Frame FSM with registered per-channel en/data; only the owner channel toggles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= SER_IDLE;
      idx_r      <= 5'd0;
      to_cnt_r   <= '0;
      frame_ch   <= '0;
      frame_mult <= 8'd0;
      busy       <= 1'b0;
      prog_en    <= '0;
      prog_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_DCM; i++) begin
        if ((load_s || shift_s) && (nxt_ch_s == CH_W'(i))) begin
          prog_en[i]   <= nxt_bits_s[1];
          prog_data[i] <= nxt_bits_s[0];
        end else begin
          prog_en[i]   <= 1'b0;
          prog_data[i] <= 1'b0;
        end
      end
      case (state_r)
        SER_IDLE: begin
          if (go) begin
            state_r    <= SER_SHIFT;
            idx_r      <= 5'd0;
            frame_ch   <= go_ch;
            frame_mult <= go_mult;
            busy       <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        SER_SHIFT: begin
          if (idx_r == FRAME_LAST_IDX) begin
            state_r  <= SER_WAIT_DONE;
            to_cnt_r <= '0;
          end else begin
            idx_r <= idx_r + 5'd1;
          end
        end
        SER_WAIT_DONE: begin
          if (finish_ok || finish_timeout) begin
            state_r <= SER_IDLE;
            busy    <= 1'b0;
          end else begin
            to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= SER_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_dcm_controller.sv
// Multi-DCM controller: decodes in-band commands from the work stream,
// keeps a clamped target multiplier per channel and schedules one
// programming frame at a time on the lowest-index out-of-date channel.
// Optional macro DCM_STEP_RAMP_EN: step each channel by +/-1 per frame
// toward its target instead of jumping straight to it.
module multi_dcm_controller
  import dcm_ctrl_pkg::*;
#(
  parameter int NUM_DCM            = 2,
  parameter int MAXIMUM_MULTIPLIER = 64,
  parameter int MINIMUM_MULTIPLIER = 2,
  parameter int INITIAL_MULTIPLIER = 16,
  parameter int DIVIDER            = 8,
  parameter int DONE_TIMEOUT       = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [255:0]           data2,
  input  logic [255:0]           midstate,
  multi_dcm_controller_if.master dcm_bus,
  output logic                   busy,
  output logic [NUM_DCM-1:0]     dcm_error,
  output logic [8*NUM_DCM-1:0]   cur_mult
);

  logic [7:0]      target_r   [NUM_DCM];
  logic [7:0]      cur_mult_r [NUM_DCM];
  logic            sched_ok_r;

  logic [7:0]      cmd_id_s;
  logic [7:0]      cmd_data_s;
  logic [7:0]      cmd_value_s;
  logic            cmd_valid_s;
  logic            unused_data2_s;

  logic            sel_valid_s;
  logic [CH_W-1:0] sel_ch_s;
  logic [7:0]      sel_target_s;
  logic [7:0]      sel_cur_s;
  logic [7:0]      prog_mult_s;
  logic            go_s;

  logic [NUM_DCM-1:0] ser_en_s;
  logic [NUM_DCM-1:0] ser_data_s;
  logic [CH_W-1:0]    ser_ch_s;
  logic [7:0]         ser_mult_s;
  logic               ser_finish_ok_s;
  logic               ser_finish_to_s;

  assign unused_data2_s = ^{data2[255:88], data2[31:0]};

  // Command recognition: trigger word, zero midstate and XOR check byte.
  always_comb begin
    cmd_id_s    = data2[71:64];
    cmd_data_s  = data2[79:72];
    cmd_valid_s = start
                  && (data2[63:32] == CMD_TRIGGER)
                  && (midstate == 256'd0)
                  && (data2[87:80] == (cmd_id_s ^ cmd_data_s));
    cmd_value_s = clamp_mult(cmd_data_s, 8'(MINIMUM_MULTIPLIER), 8'(MAXIMUM_MULTIPLIER));
  end

  // Lowest-index channel whose target differs from its confirmed M and is not faulted.
  always_comb begin
    sel_valid_s  = 1'b0;
    sel_ch_s     = '0;
    sel_target_s = 8'd0;
    sel_cur_s    = 8'd0;
    for (int i = NUM_DCM - 1; i >= 0; i--) begin
      if ((target_r[i] != cur_mult_r[i]) && !dcm_error[i]) begin
        sel_valid_s  = 1'b1;
        sel_ch_s     = CH_W'(i);
        sel_target_s = target_r[i];
        sel_cur_s    = cur_mult_r[i];
      end else begin
        sel_valid_s  = sel_valid_s;
      end
    end
  end

  // Multiplier to put in the next frame for the selected channel.
  always_comb begin
`ifdef DCM_STEP_RAMP_EN
    if (sel_cur_s == 8'd0) begin
      prog_mult_s = sel_target_s;
    end else if (sel_target_s > sel_cur_s) begin
      prog_mult_s = sel_cur_s + 8'd1;
    end else begin
      prog_mult_s = sel_cur_s - 8'd1;
    end
`else
    prog_mult_s = sel_target_s;
`endif
    go_s = sched_ok_r && sel_valid_s && !busy;
  end

  // Targets, confirmed multipliers and fault flags; a command wins over a timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      sched_ok_r <= 1'b0;
      for (int i = 0; i < NUM_DCM; i++) begin
        target_r[i]   <= 8'(INITIAL_MULTIPLIER);
        cur_mult_r[i] <= 8'd0;
        dcm_error[i]  <= 1'b0;
      end
    end else begin
      // Holds scheduling off for the first cycle after reset.
      sched_ok_r <= 1'b1;
      for (int i = 0; i < NUM_DCM; i++) begin
        if (cmd_valid_s && ((cmd_id_s == CMD_ID_BCAST) || (cmd_id_s == 8'(i)))) begin
          target_r[i]  <= cmd_value_s;
          dcm_error[i] <= 1'b0;
        end else if (ser_finish_to_s && (ser_ch_s == CH_W'(i))) begin
          dcm_error[i] <= 1'b1;
        end else begin
          dcm_error[i] <= dcm_error[i];
        end
        if (ser_finish_ok_s && (ser_ch_s == CH_W'(i))) begin
          cur_mult_r[i] <= ser_mult_s;
        end else begin
          cur_mult_r[i] <= cur_mult_r[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_DCM; g++) begin : g_cur
    assign cur_mult[8*g +: 8] = cur_mult_r[g];
  end

  assign dcm_bus.dcm_prog_en   = ser_en_s;
  assign dcm_bus.dcm_prog_data = ser_data_s;

  dcm_prog_serializer #(
    .NUM_DCM      (NUM_DCM),
    .DIVIDER      (DIVIDER),
    .DONE_TIMEOUT (DONE_TIMEOUT)
  ) u_ser (
    .clk            (clk),
    .reset          (reset),
    .go             (go_s),
    .go_ch          (sel_ch_s),
    .go_mult        (prog_mult_s),
    .prog_done      (dcm_bus.dcm_prog_done),
    .prog_en        (ser_en_s),
    .prog_data      (ser_data_s),
    .busy           (busy),
    .frame_ch       (ser_ch_s),
    .frame_mult     (ser_mult_s),
    .finish_ok      (ser_finish_ok_s),
    .finish_timeout (ser_finish_to_s)
  );

endmodule

// File: tb/tb_multi_dcm_controller.sv
// Directed bench for multi_dcm_controller (NUM_DCM=2, default parameters).
module tb_multi_dcm_controller;

  localparam int NUM_DCM = 2;
  // Expected en per frame state (bit k = state k), fixed-data mask and values.
  localparam logic [26:0] EN_PAT   = 27'h27FE3FF;
  localparam logic [26:0] DAT_MASK = 27'h7807C03;
  localparam logic [26:0] DAT_FIX  = 27'h0006001;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] data2;
  logic [255:0] midstate;
  logic         busy;
  logic [1:0]   dcm_error;
  logic [15:0]  cur_mult;
  logic [1:0]   done_r;

  int checks = 0;
  int errors = 0;

  multi_dcm_controller_if #(.NUM_DCM(NUM_DCM)) dcm_bus ();
  assign dcm_bus.dcm_prog_done = done_r;

  multi_dcm_controller #(.NUM_DCM(NUM_DCM)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data2     (data2),
    .midstate  (midstate),
    .dcm_bus   (dcm_bus),
    .busy      (busy),
    .dcm_error (dcm_error),
    .cur_mult  (cur_mult)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] make_cmd(input logic [7:0] id, input logic [7:0] dat, input bit good);
    logic [255:0] w;
    w = 256'd0;
    w[63:32] = 32'hFFFF_FFFF;
    w[71:64] = id;
    w[79:72] = dat;
    w[87:80] = good ? (id ^ dat) : ~(id ^ dat);
    return w;
  endfunction

  // Presents one command for one clock; called and returns on a negedge.
  task automatic send_cmd(input logic [7:0] id, input logic [7:0] dat, input bit good);
    data2 = make_cmd(id, dat, good);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data2 = 256'd0;
  endtask

  // Waits for a frame on channel ch and checks it against the fixed pattern and M.
  task automatic capture(input int ch, input logic [7:0] exp_m, input int inject_at,
                         input int abort_at, output bit aborted);
    logic [26:0] en_v;
    logic [26:0] dat_v;
    logic [1:0]  own;
    bit          other_act;
    bit          busy_low;
    int          waited;
    aborted   = 1'b0;
    other_act = 1'b0;
    busy_low  = 1'b0;
    en_v      = '0;
    dat_v     = '0;
    waited    = 0;
    own       = (ch == 0) ? 2'b01 : 2'b10;
    while (dcm_bus.dcm_prog_en[ch] !== 1'b1 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    chk($sformatf("frame_start ch%0d M%0d", ch, exp_m), 32'(waited < 3000), 32'd1);
    if (waited >= 3000) return;
    for (int k = 0; k < 27; k++) begin
      if (k > 0) @(negedge clk);
      en_v[k]  = dcm_bus.dcm_prog_en[ch];
      dat_v[k] = dcm_bus.dcm_prog_data[ch];
      if (((dcm_bus.dcm_prog_en | dcm_bus.dcm_prog_data) & ~own) != 2'b00) other_act = 1'b1;
      if (busy !== 1'b1) busy_low = 1'b1;
      if (k == inject_at) begin
        data2 = make_cmd(8'hFF, 8'd20, 1'b1);
        start = 1'b1;
      end
      if (k == inject_at + 1) begin
        start = 1'b0;
        data2 = 256'd0;
      end
      if (k == abort_at) begin
        reset   = 1'b1;
        aborted = 1'b1;
        return;
      end
    end
    chk($sformatf("en_pattern ch%0d M%0d", ch, exp_m), 32'(en_v), 32'(EN_PAT));
    chk($sformatf("fixed_data ch%0d M%0d", ch, exp_m), 32'(dat_v & DAT_MASK), 32'(DAT_FIX));
    chk($sformatf("d_minus_1 ch%0d", ch), 32'(dat_v[9:2]), 32'd7);
    chk($sformatf("m_minus_1 ch%0d", ch), 32'(dat_v[22:15]), 32'(exp_m - 8'd1));
    chk($sformatf("other_quiet ch%0d", ch), 32'(other_act), 32'd0);
    chk($sformatf("busy_in_frame ch%0d", ch), 32'(busy_low), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ab;
    int n;
    bit busy_seen;
    reset    = 1'b1;
    start    = 1'b0;
    data2    = 256'd0;
    midstate = 256'd0;
    done_r   = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en", 32'(dcm_bus.dcm_prog_en), 32'd0);
    chk("rst_data", 32'(dcm_bus.dcm_prog_data), 32'd0);
    chk("rst_cur_mult", 32'(cur_mult), 32'd0);
    chk("rst_error", 32'(dcm_error), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("no_frame_1cyc_after_reset", 32'(dcm_bus.dcm_prog_en), 32'd0);

    // Power-up programming: ch0 then ch1 at INITIAL.
    capture(0, 8'd16, -1, -1, ab);
    @(negedge clk);
    chk("cur0_init", 32'(cur_mult[7:0]), 32'd16);
    capture(1, 8'd16, -1, -1, ab);
    @(negedge clk);
    chk("cur_init_both", 32'(cur_mult), 32'h1010);
    repeat (3) @(negedge clk);
    chk("idle_after_init", 32'(busy), 32'd0);

`ifdef DCM_STEP_RAMP_EN
    send_cmd(8'd0, 8'd19, 1'b1);
    capture(0, 8'd17, -1, -1, ab);
    @(negedge clk);
    chk("ramp_cur0_17", 32'(cur_mult[7:0]), 32'd17);
    capture(0, 8'd18, -1, -1, ab);
    @(negedge clk);
    capture(0, 8'd19, -1, -1, ab);
    @(negedge clk);
    chk("ramp_cur0_19", 32'(cur_mult[7:0]), 32'd19);
    repeat (3) @(negedge clk);
    chk("ramp_idle", 32'(busy), 32'd0);
`else
    // Clamping high and low, then rejected commands.
    send_cmd(8'd1, 8'd200, 1'b1);
    capture(1, 8'd64, -1, -1, ab);
    @(negedge clk);
    chk("clamp_high_cur1", 32'(cur_mult[15:8]), 32'd64);
    send_cmd(8'd1, 8'd1, 1'b1);
    capture(1, 8'd2, -1, -1, ab);
    @(negedge clk);
    chk("clamp_low_cur1", 32'(cur_mult[15:8]), 32'd2);
    send_cmd(8'd1, 8'd50, 1'b0);
    send_cmd(8'd5, 8'd50, 1'b1);
    busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    chk("rejected_cmd_no_busy", 32'(busy_seen), 32'd0);
    chk("rejected_cmd_cur", 32'(cur_mult), 32'h0210);

    // Timeout on ch0, ch1 still served, then error cleared by a new command.
    done_r = 2'b10;
    send_cmd(8'd0, 8'd30, 1'b1);
    send_cmd(8'd1, 8'd40, 1'b1);
    capture(0, 8'd30, -1, -1, ab);
    n = 0;
    while (dcm_error[0] !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd1023);
    chk("timeout_error_flags", 32'(dcm_error), 32'd1);
    chk("timeout_cur0_kept", 32'(cur_mult[7:0]), 32'd16);
    capture(1, 8'd40, -1, -1, ab);
    @(negedge clk);
    chk("after_timeout_cur1", 32'(cur_mult[15:8]), 32'd40);
    repeat (5) @(negedge clk);
    chk("faulted_ch_not_rescheduled", 32'(busy), 32'd0);
    done_r = 2'b11;
    send_cmd(8'd0, 8'd30, 1'b1);
    chk("error_cleared_by_cmd", 32'(dcm_error), 32'd0);
    capture(0, 8'd30, -1, -1, ab);
    @(negedge clk);
    chk("recovered_cur", 32'(cur_mult), 32'h281E);

    // Broadcast mid-frame: current frame keeps its M.
    send_cmd(8'd0, 8'd25, 1'b1);
    capture(0, 8'd25, 5, -1, ab);
    @(negedge clk);
    chk("inflight_cur0_25", 32'(cur_mult[7:0]), 32'd25);
    capture(0, 8'd20, -1, -1, ab);
    @(negedge clk);
    capture(1, 8'd20, -1, -1, ab);
    @(negedge clk);
    chk("broadcast_cur", 32'(cur_mult), 32'h1414);

    // Reset in frame state 12.
    send_cmd(8'd0, 8'd50, 1'b1);
    capture(0, 8'd50, -1, 12, ab);
    chk("abort_reached", 32'(ab), 32'd1);
    @(negedge clk);
    chk("abort_en", 32'(dcm_bus.dcm_prog_en), 32'd0);
    chk("abort_data", 32'(dcm_bus.dcm_prog_data), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cur", 32'(cur_mult), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_no_early_frame", 32'(dcm_bus.dcm_prog_en), 32'd0);
    capture(0, 8'd16, -1, -1, ab);
    @(negedge clk);
    capture(1, 8'd16, -1, -1, ab);
    @(negedge clk);
    chk("reprogram_after_reset", 32'(cur_mult), 32'h1010);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
